vsync_decoder: RTL and testbench

- Receive-side counterpart of the vertical timing generator. Monitors an incoming active-high vsync level and a one-cycle-per-line strobe, and recovers the line position within the frame.
- Checks frame length and sync pulse width against 640x480@60Hz vertical timing, and declares lock after consecutive good frames.
- Once locked, regenerates the visible-area enable and the 9-bit row index for downstream capture/framebuffer write logic.

---
 rtl/vsync_decoder.sv | 173 +++++++++++++++++
 tb/tb_vsync_decoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vsync_decoder.sv
// rtl/vsync_decoder.sv - vsync timing recovery, lock detect and visible-row decode
//
// Purpose:
//   Follows an incoming vsync level together with a one-cycle-per-line strobe.
//   Measures the length of each frame and the width of each vsync pulse against
//   640x480@60Hz vertical timing, and declares lock after LOCK_FRAMES
//   consecutive good frames. While locked, it regenerates the visible-line
//   enable and the row index for downstream capture logic.
//
// Ports:
//   clk            system clock
//   i_sclr         synchronous active-high reset
//   i_hen          line strobe, one clk-cycle pulse per line
//   i_vsync        incoming vsync, active-high, sampled only when i_hen=1
//   o_locked       frame timing locked
//   o_frame_start  one-cycle pulse after a strobe that saw a vsync rising edge
//   o_err          one-cycle pulse after a bad-frame or timeout strobe
//   o_lines        last measured frame length in lines
//   o_addr_enb     current line is visible (only while locked)
//   o_idx          visible row index 0..479, 0 outside the visible area

module vsync_decoder #(
  parameter int VSYNC_PULSE_UTIME  = 2,
  parameter int BACK_PORCH_UTIME   = 35,
  parameter int VISIBLE_AREA_UTIME = 515,
  parameter int COUNTER            = 525,
  parameter int COUNTER_BIT        = 10,
  parameter int LOCK_FRAMES        = 2
) (
  input  logic                   clk,
  input  logic                   i_sclr,
  input  logic                   i_hen,
  input  logic                   i_vsync,
  output logic                   o_locked,
  output logic                   o_frame_start,
  output logic                   o_err,
  output logic [COUNTER_BIT-1:0] o_lines,
  output logic                   o_addr_enb,
  output logic [8:0]             o_idx
);

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_TRACK  = 1'b1;

  localparam logic [COUNTER_BIT-1:0] CNT_MAX  = {COUNTER_BIT{1'b1}};
  localparam logic [COUNTER_BIT-1:0] BP_LINE  = COUNTER_BIT'(BACK_PORCH_UTIME);
  localparam logic [COUNTER_BIT-1:0] VA_LINE  = COUNTER_BIT'(VISIBLE_AREA_UTIME);
  localparam logic [COUNTER_BIT:0]   LEN_GOOD = (COUNTER_BIT+1)'(COUNTER);
  localparam logic [3:0]             PW_GOOD  = 4'(VSYNC_PULSE_UTIME);
  localparam logic [3:0]             PW_MAX   = 4'hF;
  localparam logic [2:0]             LOCK_N   = 3'(LOCK_FRAMES);

  logic [0:0]             state;
  logic [COUNTER_BIT-1:0] cnt;
  logic [3:0]             pw;
  logic                   pw_stop;
  logic                   prev;
  logic [2:0]             good_cnt;

  logic [0:0]             nxt_state;
  logic [COUNTER_BIT-1:0] nxt_cnt;
  logic [3:0]             nxt_pw;
  logic                   nxt_pw_stop;
  logic [2:0]             nxt_good;
  logic                   nxt_locked;
  logic                   nxt_fs;
  logic                   nxt_err;
  logic [COUNTER_BIT-1:0] nxt_lines;
  logic [COUNTER_BIT:0]   len;
  logic                   nxt_vis;
  logic [8:0]             nxt_idx;
  logic                   rise;

  assign rise = i_vsync & ~prev;

  // Per-strobe next state; only committed on edges where i_hen=1.
  always_comb begin
    nxt_state   = state;
    nxt_cnt     = cnt;
    nxt_pw      = pw;
    nxt_pw_stop = pw_stop;
    nxt_good    = good_cnt;
    nxt_locked  = o_locked;
    nxt_fs      = 1'b0;
    nxt_err     = 1'b0;
    nxt_lines   = o_lines;
    // One extra bit so a saturated counter measures as 2^COUNTER_BIT.
    len         = {1'b0, cnt} + 1'b1;

    if (state == ST_SEARCH) begin
      if (rise) begin
        nxt_cnt     = '0;
        nxt_pw      = 4'd1;
        nxt_pw_stop = 1'b0;
        nxt_fs      = 1'b1;
        nxt_state   = ST_TRACK;
      end
    end else if (rise) begin
      nxt_lines = len[COUNTER_BIT-1:0];
      if (len == LEN_GOOD && pw == PW_GOOD) begin
        if (good_cnt < LOCK_N) begin
          nxt_good = good_cnt + 3'd1;
        end
        if (nxt_good == LOCK_N) begin
          nxt_locked = 1'b1;
        end
      end else begin
        nxt_good   = '0;
        nxt_locked = 1'b0;
        nxt_err    = 1'b1;
      end
      nxt_cnt     = '0;
      nxt_pw      = 4'd1;
      nxt_pw_stop = 1'b0;
      nxt_fs      = 1'b1;
    end else if (cnt == CNT_MAX) begin
      // No rise within the counter range: the source is gone, start over.
      nxt_err    = 1'b1;
      nxt_locked = 1'b0;
      nxt_good   = '0;
      nxt_state  = ST_SEARCH;
    end else begin
      nxt_cnt = cnt + 1'b1;
      // Pulse width only counts the first high run after the rise.
      if (!i_vsync) begin
        nxt_pw_stop = 1'b1;
      end else if (!pw_stop && pw != PW_MAX) begin
        nxt_pw = pw + 4'd1;
      end
    end
  end

  // Visible decode works on the post-update line count and lock.
  always_comb begin
    nxt_vis = nxt_locked && (nxt_cnt >= BP_LINE) && (nxt_cnt < VA_LINE);
    nxt_idx = nxt_vis ? 9'(nxt_cnt - BP_LINE) : 9'd0;
  end

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      state         <= ST_SEARCH;
      cnt           <= '0;
      pw            <= '0;
      pw_stop       <= 1'b0;
      prev          <= 1'b0;
      good_cnt      <= '0;
      o_locked      <= 1'b0;
      o_frame_start <= 1'b0;
      o_err         <= 1'b0;
      o_lines       <= '0;
      o_addr_enb    <= 1'b0;
      o_idx         <= '0;
    end else begin
      o_frame_start <= 1'b0;
      o_err         <= 1'b0;
      if (i_hen) begin
        prev          <= i_vsync;
        state         <= nxt_state;
        cnt           <= nxt_cnt;
        pw            <= nxt_pw;
        pw_stop       <= nxt_pw_stop;
        good_cnt      <= nxt_good;
        o_locked      <= nxt_locked;
        o_frame_start <= nxt_fs;
        o_err         <= nxt_err;
        o_lines       <= nxt_lines;
        o_addr_enb    <= nxt_vis;
        o_idx         <= nxt_idx;
      end
    end
  end

endmodule

// File: tb/tb_vsync_decoder.sv
// tb/tb_vsync_decoder.sv - self-checking bench for vsync_decoder

module tb_vsync_decoder;

  logic       clk = 1'b0;
  logic       i_sclr;
  logic       i_hen;
  logic       i_vsync;
  logic       o_locked;
  logic       o_frame_start;
  logic       o_err;
  logic [9:0] o_lines;
  logic       o_addr_enb;
  logic [8:0] o_idx;

  always #5 clk = ~clk;

  vsync_decoder dut (
    .clk           (clk),
    .i_sclr        (i_sclr),
    .i_hen         (i_hen),
    .i_vsync       (i_vsync),
    .o_locked      (o_locked),
    .o_frame_start (o_frame_start),
    .o_err         (o_err),
    .o_lines       (o_lines),
    .o_addr_enb    (o_addr_enb),
    .o_idx         (o_idx)
  );

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: frame position is the number of strobes since the last
  // accepted rise; pulse width is the length of the opening high run.
  bit m_track, m_prev, m_run_open, m_locked, m_fs, m_err, m_enb;
  int m_since, m_run, m_good, m_lines, m_idx;

  task automatic model_step(input bit hen, input bit vs, input bit sclr);
    bit rise;
    int len;
    m_fs  = 0;
    m_err = 0;
    if (sclr) begin
      m_track = 0; m_prev = 0; m_run_open = 0; m_locked = 0;
      m_since = 0; m_run = 0; m_good = 0; m_lines = 0;
      m_enb = 0; m_idx = 0;
      return;
    end
    if (!hen) return;
    rise   = vs && !m_prev;
    m_prev = vs;
    if (!m_track) begin
      if (rise) begin
        m_track = 1; m_since = 0; m_run = 1; m_run_open = 1; m_fs = 1;
      end
    end else if (rise) begin
      len     = m_since + 1;
      m_lines = len % 1024;
      if (len == 525 && m_run == 2) begin
        if (m_good < 2) m_good++;
        if (m_good == 2) m_locked = 1;
      end else begin
        m_good = 0; m_locked = 0; m_err = 1;
      end
      m_since = 0; m_run = 1; m_run_open = 1; m_fs = 1;
    end else if (m_since == 1023) begin
      m_err = 1; m_locked = 0; m_good = 0; m_track = 0;
    end else begin
      m_since++;
      if (m_run_open && vs) m_run = (m_run < 15) ? m_run + 1 : 15;
      else m_run_open = 0;
    end
    m_enb = m_locked && m_since >= 35 && m_since < 515;
    m_idx = m_enb ? m_since - 35 : 0;
  endtask

  task automatic compare_all();
    check_val("locked",      32'(o_locked),      32'(m_locked));
    check_val("frame_start", 32'(o_frame_start), 32'(m_fs));
    check_val("err",         32'(o_err),         32'(m_err));
    check_val("lines",       32'(o_lines),       m_lines);
    check_val("addr_enb",    32'(o_addr_enb),    32'(m_enb));
    check_val("idx",         32'(o_idx),         m_idx);
  endtask

  // One clock: drive at negedge, model follows the posedge, sample at negedge.
  task automatic tick(input bit hen, input bit vs, input bit sclr);
    i_hen   = hen;
    i_vsync = vs;
    i_sclr  = sclr;
    @(posedge clk);
    model_step(hen, vs, sclr);
    @(negedge clk);
    compare_all();
  endtask

  // Snapshot of DUT outputs right after the most recent strobe.
  logic       sn_fs, sn_err, sn_locked, sn_enb;
  logic [9:0] sn_lines;
  logic [8:0] sn_idx;

  task automatic strobe(input bit vs);
    tick(1'b1, vs, 1'b0);
    sn_fs = o_frame_start; sn_err = o_err; sn_locked = o_locked;
    sn_enb = o_addr_enb; sn_lines = o_lines; sn_idx = o_idx;
    // Idle gaps with random vsync glitches that must be ignored.
    repeat ($urandom_range(0, 2)) tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  // Values seen at the first strobe of a frame, and visible-area stats.
  logic       s_fs, s_err, s_locked;
  logic [9:0] s_lines;
  int enb_cnt, first_line, first_idx, last_line, last_idx;

  task automatic frame(input int len, input int pw);
    enb_cnt = 0; first_line = -1; first_idx = -1; last_line = -1; last_idx = -1;
    for (int i = 0; i < len; i++) begin
      strobe(i < pw);
      if (i == 0) begin
        s_fs = sn_fs; s_err = sn_err; s_locked = sn_locked; s_lines = sn_lines;
      end
      if (sn_enb) begin
        enb_cnt++;
        if (first_line < 0) begin first_line = i; first_idx = int'(sn_idx); end
        last_line = i; last_idx = int'(sn_idx);
      end
    end
  endtask

  int err_count, err_at;

  task automatic hold(input int n, input bit vs);
    err_count = 0; err_at = -1;
    for (int i = 1; i <= n; i++) begin
      strobe(vs);
      if (sn_err) begin
        err_count++;
        if (err_at < 0) err_at = i;
      end
    end
  endtask

  initial begin
    i_sclr = 1'b1; i_hen = 1'b0; i_vsync = 1'b0;
    @(negedge clk);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    check_val("rst_locked", 32'(o_locked), 0);
    check_val("rst_lines",  32'(o_lines),  0);

    // Nominal lock-up: lock appears at the third rise.
    frame(525, 2);
    frame(525, 2);
    check_val("nom_unlocked_2nd", 32'(s_locked), 0);
    frame(525, 2);
    check_val("nom_lock_3rd", 32'(s_locked), 1);
    check_val("nom_lines",    32'(s_lines),  525);
    check_val("nom_fs",       32'(s_fs),     1);
    frame(525, 2);
    check_val("vis_count",    enb_cnt,    480);
    check_val("vis_first",    first_line, 35);
    check_val("vis_idx0",     first_idx,  0);
    check_val("vis_last",     last_line,  514);
    check_val("vis_idx479",   last_idx,   479);

    // Short frame.
    frame(524, 2);
    frame(525, 2);
    check_val("short_err",    32'(s_err),    1);
    check_val("short_lines",  32'(s_lines),  524);
    check_val("short_unlock", 32'(s_locked), 0);
    frame(525, 2);
    frame(525, 2);
    check_val("short_relock", 32'(s_locked), 1);

    // Wide vsync pulse.
    frame(525, 3);
    frame(525, 2);
    check_val("pw_err",    32'(s_err),    1);
    check_val("pw_unlock", 32'(s_locked), 0);
    check_val("pw_lines",  32'(s_lines),  525);
    frame(525, 2);
    frame(525, 2);
    check_val("pw_relock", 32'(s_locked), 1);

    // Timeout: frame left the count at 524, saturation at 1023, timeout next.
    hold(1100, 1'b0);
    check_val("to_err_count", err_count, 1);
    check_val("to_err_at",    err_at,    500);
    check_val("to_unlock",    32'(o_locked), 0);
    frame(525, 2);
    check_val("to_fs",    32'(s_fs),  1);
    check_val("to_noerr", 32'(s_err), 0);
    frame(525, 2);
    frame(525, 2);
    check_val("to_relock", 32'(s_locked), 1);

    // Reset in mid-frame while locked.
    frame(200, 2);
    check_val("pre_rst_locked", 32'(o_locked),   1);
    check_val("pre_rst_enb",    32'(o_addr_enb), 1);
    tick(1'b1, 1'b1, 1'b1);
    check_val("mid_rst_locked", 32'(o_locked),      0);
    check_val("mid_rst_enb",    32'(o_addr_enb),    0);
    check_val("mid_rst_idx",    32'(o_idx),         0);
    check_val("mid_rst_fs",     32'(o_frame_start), 0);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'(i % 2 == 0), 1'b0);
      check_val("glitch_fs", 32'(o_frame_start), 0);
    end
    frame(525, 2);
    check_val("rst_search_fs", 32'(s_fs), 1);
    frame(525, 2);
    check_val("rst_unlocked", 32'(s_locked), 0);
    frame(525, 2);
    check_val("rst_relock", 32'(s_locked), 1);
    frame(525, 2);
    check_val("rst_vis_count", enb_cnt, 480);

    // Vsync stuck high: one rise, then timeout after a full counter range.
    hold(1100, 1'b1);
    check_val("hi_err_count", err_count, 2'd1);
    check_val("hi_err_at",    err_at,    1025);
    hold(3, 1'b0);

    // Randomised frames, mostly nominal, some off in length or pulse width.
    for (int f = 0; f < 8; f++) begin
      int len, pw;
      len = ($urandom_range(0, 3) == 0) ? 523 + $urandom_range(0, 4) : 525;
      pw  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 18) : 2;
      frame(len, pw);
    end
    frame(525, 2);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
